// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU (p0) and the loader (p1).
// Ports: px_* valid/ready requests with lock, px_rvalid/px_rdata responses, mem_* memory side, owner debug.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_lock,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic          rr_ptr, rr_nxt;
    logic [CW-1:0] beat_cnt, beat_nxt;
    logic          gnt0, gnt1;
    logic          xfer, sel_lock, last_beat;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            IDLE: begin
                gnt0 = p0_valid & (~p1_valid | ~rr_ptr);
                gnt1 = p1_valid & (~p0_valid | rr_ptr);
            end
            OWN0: gnt0 = p0_valid;
            OWN1: gnt1 = p1_valid;
            default: ;
        endcase
        // nothing may be accepted while reset is held
        gnt0 = gnt0 & rst;
        gnt1 = gnt1 & rst;
    end

    assign xfer      = gnt0 | gnt1;
    assign sel_lock  = gnt1 ? p1_lock : p0_lock;
    assign last_beat = (32'(beat_cnt) + 32'd1) >= 32'(MAX_BURST);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        if (xfer) begin
            // the port that just transferred loses priority
            rr_nxt = gnt0;
            if (sel_lock && !last_beat) begin
                state_nxt = gnt1 ? OWN1 : OWN0;
                beat_nxt  = beat_cnt + CW'(1);
            end else begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        end else if (state != IDLE) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= gnt0 & ~p0_we;
            p1_rvalid <= gnt1 & ~p1_we;
            if (gnt0 & ~p0_we) p0_rdata <= mem_rdata;
            if (gnt1 & ~p1_we) p1_rdata <= mem_rdata;
        end
    end

    assign p0_ready  = gnt0;
    assign p1_ready  = gnt1;
    assign mem_we    = (gnt0 & p0_we) | (gnt1 & p1_we);
    assign mem_addr  = gnt1 ? p1_addr  : (gnt0 ? p0_addr  : '0);
    assign mem_wdata = gnt1 ? p1_wdata : (gnt0 ? p0_wdata : '0);
    assign owner     = state;

endmodule
